// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive path.
// FSM states, parity modes and the divisor floor.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRK_WAIT
  } state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_ODD   = 1;
  localparam int PAR_EVEN  = 2;
  localparam int MIN_LIMIT = 4;

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop rx synchronizer with falling-edge detect.
// Flops reset high so reset release never looks like a start bit.
module serial_rx_sync (
  input  logic Clk,
  input  logic Rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [2:0] q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) q <= 3'b111;
    else        q <= {q[1:0], rx};
  end

  assign rx_s = q[1];
  assign fall = q[2] & ~q[1];

endmodule

// File: rtl/serial_rx_core.sv
// Parametrised UART receiver: mid-bit sampling, error flags,
// valid/ready word hold with sticky overrun.
module serial_rx_core
  import serial_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] limit,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam logic [DIV_WIDTH-1:0] ONE =
    DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] MIN_L =
    DIV_WIDTH'(MIN_LIMIT);
  localparam logic [3:0] LAST_BIT =
    4'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t state, nxt;

  logic                 rx_s;
  logic                 fall;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] lim;
  logic [DIV_WIDTH-1:0] half;
  logic [DIV_WIDTH-1:0] lim_c;
  logic [3:0]           bitn;
  logic                 stopn;
  logic [DATA_BITS-1:0] shreg;
  logic                 pbit;
  logic                 stop_low;
  logic                 tick_h;
  logic                 tick;
  logic                 sample;
  logic                 counting;
  logic                 perr_c;
  logic                 brk_c;

  serial_rx_sync u_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign lim_c  = (limit < MIN_L) ? MIN_L : limit;
  assign tick_h = (cnt == half - ONE);
  assign tick   = (cnt == lim - ONE);
  assign busy   = (state != IDLE);
  assign brk_c  = ~|shreg & ~pbit & stop_low;

  always_comb begin
    perr_c = 1'b0;
    if (PARITY == PAR_ODD)
      perr_c = ~(^shreg ^ pbit);
    else if (PARITY == PAR_EVEN)
      perr_c = ^shreg ^ pbit;
  end

  always_comb begin
    sample   = 1'b0;
    counting = 1'b0;
    unique case (state)
      START: begin
        sample   = tick_h;
        counting = 1'b1;
      end
      DATA, serial_pkg::PARITY, STOP: begin
        sample   = tick;
        counting = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (fall) nxt = START;
      START:
        if (tick_h) nxt = rx_s ? IDLE : DATA;
      DATA:
        if (tick && bitn == LAST_BIT)
          nxt = (PARITY != PAR_NONE) ?
                serial_pkg::PARITY : STOP;
      serial_pkg::PARITY:
        if (tick) nxt = STOP;
      STOP:
        if (tick && stopn == LAST_STOP) nxt = DONE;
      DONE:
        nxt = brk_c ? BRK_WAIT : IDLE;
      BRK_WAIT:
        if (rx_s) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // Divisor is captured at the start edge; later changes are ignored.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt      <= '0;
      lim      <= MIN_L;
      half     <= '0;
      bitn     <= '0;
      stopn    <= 1'b0;
      shreg    <= '0;
      pbit     <= 1'b0;
      stop_low <= 1'b0;
    end else begin
      if (state == IDLE && fall) begin
        lim      <= lim_c;
        half     <= lim_c >> 1;
        cnt      <= '0;
        bitn     <= '0;
        stopn    <= 1'b0;
        pbit     <= 1'b0;
        stop_low <= 1'b0;
      end else if (sample) begin
        cnt <= '0;
      end else if (counting) begin
        cnt <= cnt + ONE;
      end
      if (sample && state == DATA) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        bitn  <= bitn + 4'd1;
      end
      if (sample && state == serial_pkg::PARITY)
        pbit <= rx_s;
      if (sample && state == STOP) begin
        if (!stopn) stop_low <= ~rx_s;
        stopn <= ~stopn;
      end
    end
  end

  // An accept in the DONE cycle frees the slot for the new word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data        <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (state == DONE) begin
      if (!data_valid || data_ready) begin
        data       <= shreg;
        parity_err <= perr_c;
        frame_err  <= stop_low;
        break_det  <= brk_c;
        data_valid <= 1'b1;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule
